dcw_smp: RTL and testbench
==========================

DCW_SMP -- requirements
Module: dcw_smp

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- DTC_L, 12: DTC control word width.
- THERM_B, 3: number of MSBs encoded as thermometer.
- BIN_W, DTC_L-THERM_B = 9: binary segment width.
- THERM_W, 2**THERM_B-1 = 7: thermometer output width.

REQ-002 Ports, one per line (name, direction, width, meaning):
- REFDTC, input, 1: sampling clock, DTC-domain reference edge; the only clock.
- ARST, input, 1: reset, asynchronous, active-high.
- DCWIN, input, DTC_L: delay control word from the digital loop, stable around the REFDTC rising edge.
- LOOP_TEMP_CODE, output, THERM_W: thermometer code driving the coarse DTC unit cells.
- LOOP_BINARY_OUT, output, BIN_W: binary code driving the fine DTC cells.
- DCWOUT, output, DTC_L: retimed full control word for the behavioural DTC.

REQ-003 The block SHALL have one clock domain (REFDTC rising edge) and reset SHALL be asynchronous and active-high (ARST).

Function
REQ-004 On each REFDTC rising edge with ARST low, the block SHALL capture DCWIN and update all three outputs from that captured value; latency SHALL be exactly one edge.
REQ-005 LOOP_BINARY_OUT SHALL equal captured DCWIN[BIN_W-1:0].
REQ-006 LOOP_TEMP_CODE[i] SHALL be 1 if and only if captured DCWIN[DTC_L-1:BIN_W] > i, for i = 0..THERM_W-1.
REQ-007 LOOP_TEMP_CODE SHALL always be monotonic: bit i set implies every bit below i is set.
REQ-008 DCWOUT SHALL equal popcount(LOOP_TEMP_CODE) * 2**BIN_W + LOOP_BINARY_OUT, which SHALL equal captured DCWIN bit for bit.
REQ-009 Every output SHALL be driven directly by a flip-flop clocked by REFDTC, with no combinational logic after the registers, so that all output bits change on the same edge and no glitches reach the DTC.
REQ-010 Boundary values:
- DCWIN = 0 SHALL give TEMP = 7'h00, BIN = 0, DCWOUT = 0.
- DCWIN = 4095 SHALL give TEMP = 7'h7F, BIN = 511, DCWOUT = 4095.
REQ-011 Carry across a segment boundary (for example 511 -> 512) SHALL update the thermometer and binary fields on the same edge.
REQ-012 Between REFDTC rising edges, outputs SHALL hold their value regardless of DCWIN activity.

Reset
REQ-013 While ARST is high, LOOP_TEMP_CODE, LOOP_BINARY_OUT and DCWOUT SHALL be 0, and clocking SHALL be ignored.
REQ-014 Assertion of ARST in mid-operation SHALL clear all outputs immediately, without waiting for an edge.
REQ-015 If ARST is deasserted coincident with a REFDTC edge, the outputs SHALL stay 0 for that edge, and the first capture SHALL occur on the next REFDTC rising edge.

Structure
REQ-016 The constants DTC_L, THERM_B, BIN_W and THERM_W SHALL live in a shared package, dtc_pkg, which the digital loop and the DTC model also use.
REQ-017 The binary-to-thermometer conversion SHALL be a separate combinational sub-module, therm_dec (input THERM_B bits, output THERM_W bits), placed before the output registers.

Verification
REQ-018 Reset: assert ARST while outputs are nonzero -> all outputs read 0 immediately; release ARST, then apply DCWIN = 1000 -> TEMP = 7'h01, BIN = 488, DCWOUT = 1000 after the next rising edge.
REQ-019 Latency: change DCWIN = 2048 midway between edges -> outputs unchanged until the next rising edge, then TEMP = 7'h0F, BIN = 0, DCWOUT = 2048.
REQ-020 Extremes: DCWIN = 0 and then 4095 on successive edges -> (7'h00, 0, 0) then (7'h7F, 511, 4095).
REQ-021 Segment carry: DCWIN = 511 then 512 -> (7'h00, 511) then (7'h01, 0), each field changing on one edge.
REQ-022 Random sweep: 10000 random DCWIN values -> DCWOUT equals the previous-edge DCWIN, TEMP is always monotonic, and popcount(TEMP) equals DCWIN[11:9].

Source files
------------

// File: rtl/dtc_pkg.sv
// Shared DTC word-format constants, used by the sampler, the digital loop and the DTC model.
package dtc_pkg;

    // Full delay control word width
    localparam int DTC_L   = 12;
    // Number of MSBs that drive the coarse thermometer-coded unit cells
    localparam int THERM_B = 3;
    // Width of the fine binary segment
    localparam int BIN_W   = DTC_L - THERM_B;
    // Number of coarse unit cells, one per thermometer bit
    localparam int THERM_W = (2 ** THERM_B) - 1;

    typedef logic [DTC_L-1:0]   dcw_t;
    typedef logic [THERM_W-1:0] therm_t;
    typedef logic [BIN_W-1:0]   bin_t;

endpackage

// File: rtl/dcw_smp_therm_dec.sv
// Binary-to-thermometer decoder for the coarse DTC segment (purely combinational).
module therm_dec #(
    parameter int IN_W  = dtc_pkg::THERM_B,
    parameter int OUT_W = (2 ** IN_W) - 1
) (
    input  logic [IN_W-1:0]  bin_i,
    output logic [OUT_W-1:0] therm_o
);

    // Bit i is lit when the coarse code exceeds i, so the fill is monotonic from bit 0 upward
    always_comb begin
        therm_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            therm_o[i] = (int'(bin_i) > i);
        end
    end

endmodule

// File: rtl/dcw_smp.sv
// DCW sampler: retimes the delay control word on REFDTC and splits it into
// a thermometer-coded coarse segment and a binary fine segment. Every output
// comes straight from a flop so all DTC cells switch on the same edge.
module dcw_smp #(
    parameter int DTC_L   = dtc_pkg::DTC_L,
    parameter int THERM_B = dtc_pkg::THERM_B,
    parameter int BIN_W   = DTC_L - THERM_B,
    parameter int THERM_W = (2 ** THERM_B) - 1
) (
    input  logic               REFDTC,
    input  logic               ARST,
    input  logic [DTC_L-1:0]   DCWIN,
    output logic [THERM_W-1:0] LOOP_TEMP_CODE,
    output logic [BIN_W-1:0]   LOOP_BINARY_OUT,
    output logic [DTC_L-1:0]   DCWOUT
);

    logic [THERM_W-1:0] therm_d;
    logic [THERM_W-1:0] therm_q;
    logic [BIN_W-1:0]   bin_d;
    logic [BIN_W-1:0]   bin_q;
    logic [DTC_L-1:0]   dcw_d;
    logic [DTC_L-1:0]   dcw_q;

    // Decode happens ahead of the registers so no logic sits between flops and DTC
    therm_dec #(
        .IN_W  (THERM_B),
        .OUT_W (THERM_W)
    ) u_therm_dec (
        .bin_i   (DCWIN[DTC_L-1:BIN_W]),
        .therm_o (therm_d)
    );

    // Next-state values: fine segment and full word pass straight through
    always_comb begin
        bin_d = DCWIN[BIN_W-1:0];
        dcw_d = DCWIN;
    end

    // Output registers: cleared asynchronously, loaded together on every REFDTC edge
    always_ff @(posedge REFDTC or posedge ARST) begin
        if (ARST) begin
            therm_q <= '0;
            bin_q   <= '0;
            dcw_q   <= '0;
        end else begin
            therm_q <= therm_d;
            bin_q   <= bin_d;
            dcw_q   <= dcw_d;
        end
    end

    assign LOOP_TEMP_CODE  = therm_q;
    assign LOOP_BINARY_OUT = bin_q;
    assign DCWOUT          = dcw_q;

endmodule

// File: tb/tb_dcw_smp.sv
// Self-checking bench for dcw_smp: reset, latency/hold, table of directed
// vectors (including extremes and segment carry) and a random sweep.
module tb_dcw_smp;

    logic        REFDTC;
    logic        ARST;
    logic [11:0] DCWIN;
    logic [6:0]  LOOP_TEMP_CODE;
    logic [8:0]  LOOP_BINARY_OUT;
    logic [11:0] DCWOUT;

    int checks;
    int failures;

    typedef struct {
        logic [11:0] din;
        logic [6:0]  exp_temp;
        logic [8:0]  exp_bin;
        logic [11:0] exp_dcw;
    } vec_t;

    vec_t vecs [12];

    dcw_smp dut (
        .REFDTC          (REFDTC),
        .ARST            (ARST),
        .DCWIN           (DCWIN),
        .LOOP_TEMP_CODE  (LOOP_TEMP_CODE),
        .LOOP_BINARY_OUT (LOOP_BINARY_OUT),
        .DCWOUT          (DCWOUT)
    );

    initial REFDTC = 1'b0;
    always #5 REFDTC = ~REFDTC;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [6:0] t, input logic [8:0] b, input logic [11:0] d);
        chk({name, ".temp"}, 32'(LOOP_TEMP_CODE), 32'(t));
        chk({name, ".bin"},  32'(LOOP_BINARY_OUT), 32'(b));
        chk({name, ".dcw"},  32'(DCWOUT), 32'(d));
    endtask

    // Independent thermometer model: n ones from bit 0 upward
    function automatic logic [6:0] therm_model(input logic [2:0] n);
        logic [7:0] full;
        full = 8'h7F;
        return 7'(full >> (3'd7 - n));
    endfunction

    initial begin
        logic [11:0] rnd;
        logic [7:0]  t8;
        checks   = 0;
        failures = 0;

        // Hand-computed vectors; 511 -> 512 and 0 -> 4095 are consecutive on purpose
        vecs[0]  = '{12'd0,    7'h00, 9'd0,   12'd0};
        vecs[1]  = '{12'd4095, 7'h7F, 9'd511, 12'd4095};
        vecs[2]  = '{12'd511,  7'h00, 9'd511, 12'd511};
        vecs[3]  = '{12'd512,  7'h01, 9'd0,   12'd512};
        vecs[4]  = '{12'd1000, 7'h01, 9'd488, 12'd1000};
        vecs[5]  = '{12'd2048, 7'h0F, 9'd0,   12'd2048};
        vecs[6]  = '{12'd1,    7'h00, 9'd1,   12'd1};
        vecs[7]  = '{12'd3583, 7'h3F, 9'd511, 12'd3583};
        vecs[8]  = '{12'd2560, 7'h1F, 9'd0,   12'd2560};
        vecs[9]  = '{12'd1536, 7'h07, 9'd0,   12'd1536};
        vecs[10] = '{12'd3584, 7'h7F, 9'd0,   12'd3584};
        vecs[11] = '{12'd1023, 7'h01, 9'd511, 12'd1023};

        // Reset held across edges with a nonzero input: outputs stay 0
        ARST  = 1'b1;
        DCWIN = 12'hABC;
        repeat (3) @(posedge REFDTC);
        #1;
        chk_out("reset_hold", 7'h00, 9'd0, 12'd0);

        // Release reset, first capture on the next rising edge
        @(negedge REFDTC);
        ARST  = 1'b0;
        DCWIN = 12'd1000;
        #1;
        chk_out("post_release_pre_edge", 7'h00, 9'd0, 12'd0);
        @(posedge REFDTC);
        #1;
        chk_out("first_capture_1000", 7'h01, 9'd488, 12'd1000);

        // Latency/hold: change input between edges, outputs must not move
        @(negedge REFDTC);
        DCWIN = 12'd2048;
        #1;
        chk_out("hold_mid_cycle", 7'h01, 9'd488, 12'd1000);
        DCWIN = 12'd4095;
        #1;
        DCWIN = 12'd2048;
        #1;
        chk_out("hold_input_toggle", 7'h01, 9'd488, 12'd1000);
        @(posedge REFDTC);
        #1;
        chk_out("latency_2048", 7'h0F, 9'd0, 12'd2048);

        // Asynchronous reset mid-cycle clears immediately
        #2;
        ARST = 1'b1;
        #1;
        chk_out("async_clear", 7'h00, 9'd0, 12'd0);
        @(posedge REFDTC);
        #1;
        chk_out("clock_ignored_in_reset", 7'h00, 9'd0, 12'd0);
        @(negedge REFDTC);
        ARST  = 1'b0;
        DCWIN = 12'd1000;
        @(posedge REFDTC);
        #1;
        chk_out("recapture_1000", 7'h01, 9'd488, 12'd1000);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            @(negedge REFDTC);
            DCWIN = vecs[i].din;
            @(posedge REFDTC);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].exp_temp, vecs[i].exp_bin, vecs[i].exp_dcw);
        end

        // Random sweep
        for (int n = 0; n < 10000; n++) begin
            @(negedge REFDTC);
            rnd   = 12'($urandom_range(0, 4095));
            DCWIN = rnd;
            @(posedge REFDTC);
            #1;
            chk("rnd.dcw",  32'(DCWOUT), 32'(rnd));
            chk("rnd.bin",  32'(LOOP_BINARY_OUT), 32'(rnd[8:0]));
            chk("rnd.temp", 32'(LOOP_TEMP_CODE), 32'(therm_model(rnd[11:9])));
            t8 = {1'b0, LOOP_TEMP_CODE};
            chk("rnd.monotonic", 32'((t8 + 8'd1) & t8), 32'd0);
            chk("rnd.popcount", 32'($countones(LOOP_TEMP_CODE)), 32'(rnd[11:9]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
